// File: rtl/cpu_types_pkg.sv
// Shared cache types: MSI line state, controller FSM state and address field widths.
package cpu_types_pkg;

  localparam int unsigned TagW  = 26;
  localparam int unsigned IdxW  = 3;
  localparam int unsigned NSets = 1 << IdxW;

  typedef logic [31:0]     word_t;
  typedef logic [TagW-1:0] tag_t;
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {
    MsiI = 2'd0,
    MsiS = 2'd1,
    MsiM = 2'd2
  } msi_t;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWb1  = 3'd1,
    StWb2  = 3'd2,
    StLd1  = 3'd3,
    StLd2  = 3'd4
  } dc_state_t;

  function automatic tag_t addr_tag(word_t a);
    return a[31:6];
  endfunction

  function automatic idx_t addr_idx(word_t a);
    return a[5:3];
  endfunction

endpackage

// File: rtl/dcache_snoop_unit.sv
// Snoop side of the data cache: live Modified-match for ccwrite, latching of the
// snooped index/tag/invalidate while ccwait is high, and the deferred MSI downgrade
// applied on the first cycle after ccwait falls.
module dcache_snoop_unit
  import cpu_types_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ccwait,
  input  logic             i_ccinv,
  input  logic [31:0]      i_snoop_addr,
  input  msi_t [NSets-1:0] i_msi,
  input  tag_t [NSets-1:0] i_tag,
  output logic             o_ccwrite,
  output logic             o_upd,
  output idx_t             o_upd_idx,
  output msi_t             o_upd_msi
);

  logic       r_snp_active;
  idx_t       r_snp_idx;
  tag_t       r_snp_tag;
  logic       r_snp_inv;

  idx_t       w_live_idx;
  tag_t       w_live_tag;
  logic       w_fire;
  logic       w_match;
  logic [2:0] w_unused_addr;

  assign w_live_idx    = addr_idx(i_snoop_addr);
  assign w_live_tag    = addr_tag(i_snoop_addr);
  assign w_unused_addr = i_snoop_addr[2:0];

  // Track snoop activity and hold the last snooped line while ccwait is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snp_active <= 1'b0;
      r_snp_idx    <= '0;
      r_snp_tag    <= '0;
      r_snp_inv    <= 1'b0;
    end else begin
      r_snp_active <= i_ccwait;
      if (i_ccwait) begin
        r_snp_idx <= w_live_idx;
        r_snp_tag <= w_live_tag;
        r_snp_inv <= i_ccinv;
      end
    end
  end

  // Live ownership response plus the state change owed once the snoop ends.
  always_comb begin
    o_ccwrite = i_ccwait && (i_msi[w_live_idx] == MsiM) && (i_tag[w_live_idx] == w_live_tag);
    w_fire    = r_snp_active && !i_ccwait;
    w_match   = (i_msi[r_snp_idx] != MsiI) && (i_tag[r_snp_idx] == r_snp_tag);
    // A clean S line only changes when invalidated.
    o_upd     = w_fire && w_match && (r_snp_inv || (i_msi[r_snp_idx] == MsiM));
    o_upd_idx = r_snp_idx;
    o_upd_msi = r_snp_inv ? MsiI : MsiS;
  end

endmodule

// File: rtl/dcache_coherence_ctrl.sv
// Direct-mapped MSI data cache controller: 8 sets x 2 words, write-back, with a
// per-CPU bus slice and snoop interface. Define DCACHE_STATS_EN to add the
// hitcount/misscount outputs.
module dcache_coherence_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        ccwrite,
  output logic        cctrans
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hitcount,
  output logic [31:0] misscount
`endif
);

  dc_state_t        r_state;
  dc_state_t        w_next_state;
  msi_t [NSets-1:0] r_msi;
  tag_t [NSets-1:0] r_tag;
  word_t            r_w0 [NSets];
  word_t            r_w1 [NSets];

  idx_t             w_idx;
  tag_t             w_tag;
  logic             w_wsel;
  logic             w_req;
  logic             w_is_wr;
  logic             w_hit;
  logic             w_bus_ok;
  logic             w_wr_hit;
  logic             w_cap0;
  logic             w_cap1;
  logic             w_install;
  logic             w_miss;
  word_t            w_bus_dstore;
  logic             w_snp_upd;
  idx_t             w_snp_idx;
  msi_t             w_snp_msi;
  logic             w_snp_conflict;
  logic [1:0]       w_unused_bits;

  assign w_idx         = addr_idx(dmemaddr);
  assign w_tag         = addr_tag(dmemaddr);
  assign w_wsel        = dmemaddr[2];
  assign w_unused_bits = dmemaddr[1:0];
  // Both enables high counts as a write.
  assign w_is_wr       = dmemWEN;
  assign w_req         = dmemREN | dmemWEN;
  assign w_hit         = (r_msi[w_idx] != MsiI) && (r_tag[w_idx] == w_tag) &&
                         (!w_is_wr || (r_msi[w_idx] == MsiM));
  // Bus requests are masked during a snoop, so no handshake can complete then.
  assign w_bus_ok      = !dwait && !ccwait;
  assign w_snp_conflict = w_snp_upd && (w_snp_idx == w_idx);
  assign dmemload      = w_wsel ? r_w1[w_idx] : r_w0[w_idx];
  assign dstore        = ccwrite ? (ccsnoopaddr[2] ? r_w1[addr_idx(ccsnoopaddr)]
                                                   : r_w0[addr_idx(ccsnoopaddr)])
                                 : w_bus_dstore;

  dcache_snoop_unit u_snoop (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_ccwait     (ccwait),
    .i_ccinv      (ccinv),
    .i_snoop_addr (ccsnoopaddr),
    .i_msi        (r_msi),
    .i_tag        (r_tag),
    .o_ccwrite    (ccwrite),
    .o_upd        (w_snp_upd),
    .o_upd_idx    (w_snp_idx),
    .o_upd_msi    (w_snp_msi)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= StIdle;
    else       r_state <= w_next_state;
  end

  // Next-state decode and processor/bus outputs.
  always_comb begin
    w_next_state = r_state;
    dhit         = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    w_bus_dstore = '0;
    cctrans      = 1'b0;
    w_wr_hit     = 1'b0;
    w_cap0       = 1'b0;
    w_cap1       = 1'b0;
    w_install    = 1'b0;
    w_miss       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_hit) begin
            // A snoop downgrade of this set on the same edge wins over the write.
            if (!(w_is_wr && w_snp_conflict)) begin
              dhit     = 1'b1;
              w_wr_hit = w_is_wr;
            end
          end else begin
            w_miss       = 1'b1;
            w_next_state = (r_msi[w_idx] == MsiM) ? StWb1 : StLd1;
          end
        end
      end
      StWb1: begin
        dWEN         = 1'b1;
        daddr        = {r_tag[w_idx], w_idx, 1'b0, 2'b00};
        w_bus_dstore = r_w0[w_idx];
        if (w_bus_ok) w_next_state = StWb2;
      end
      StWb2: begin
        dWEN         = 1'b1;
        daddr        = {r_tag[w_idx], w_idx, 1'b1, 2'b00};
        w_bus_dstore = r_w1[w_idx];
        if (w_bus_ok) w_next_state = StLd1;
      end
      StLd1: begin
        dREN    = 1'b1;
        daddr   = {w_tag, w_idx, 1'b0, 2'b00};
        cctrans = w_is_wr;
        if (w_bus_ok) begin
          w_cap0       = 1'b1;
          w_next_state = StLd2;
        end
      end
      StLd2: begin
        dREN    = 1'b1;
        daddr   = {w_tag, w_idx, 1'b1, 2'b00};
        cctrans = w_is_wr;
        if (w_bus_ok) begin
          w_cap1       = 1'b1;
          w_install    = 1'b1;
          w_next_state = StIdle;
        end
      end
      default: w_next_state = StIdle;
    endcase
    if (ccwait) begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  end

  // Line storage: processor writes, snoop downgrades, refill and install.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSets; i++) begin
        r_msi[i] <= MsiI;
        r_tag[i] <= '0;
        r_w0[i]  <= '0;
        r_w1[i]  <= '0;
      end
    end else begin
      if (w_wr_hit) begin
        if (w_wsel) r_w1[w_idx] <= dmemstore;
        else        r_w0[w_idx] <= dmemstore;
      end
      if (w_snp_upd) r_msi[w_snp_idx] <= w_snp_msi;
      // Refill overwrites the victim data, so the set is invalid until install.
      if (w_cap0) begin
        r_w0[w_idx]  <= dload;
        r_msi[w_idx] <= MsiI;
      end
      if (w_cap1) r_w1[w_idx] <= dload;
      if (w_install) begin
        r_tag[w_idx] <= w_tag;
        r_msi[w_idx] <= w_is_wr ? MsiM : MsiS;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitcount;
  logic [31:0] r_misscount;

  // Hit/miss event counters, free-running with natural wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hitcount  <= '0;
      r_misscount <= '0;
    end else begin
      if (dhit)   r_hitcount  <= r_hitcount + 32'd1;
      if (w_miss) r_misscount <= r_misscount + 32'd1;
    end
  end

  assign hitcount  = r_hitcount;
  assign misscount = r_misscount;
`endif

endmodule

// File: tb/tb_dcache_coherence_ctrl.sv
// Directed bench for dcache_coherence_ctrl: miss/refill, write upgrade, write-back,
// snoop downgrade/invalidate, snoop-vs-write collision and reset mid-refill.
module tb_dcache_coherence_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;
  logic        ccwrite, cctrans;
`ifdef DCACHE_STATS_EN
  logic [31:0] hitcount, misscount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  dcache_coherence_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .dload       (dload),
    .dwait       (dwait),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .ccwrite     (ccwrite),
    .cctrans     (cctrans)
`ifdef DCACHE_STATS_EN
    ,
    .hitcount    (hitcount),
    .misscount   (misscount)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Two-word refill with zero wait states; entered while the FSM is in LD1.
  task automatic bus_ld(input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] d1,
                        input logic exp_trans);
    dwait = 1'b0;
    dload = d0;
    #1;
    check_val("ld1_dren", {31'b0, dREN}, 32'd1);
    check_val("ld1_addr", daddr, a0);
    check_val("ld1_trans", {31'b0, cctrans}, {31'b0, exp_trans});
    step();
    dload = d1;
    #1;
    check_val("ld2_dren", {31'b0, dREN}, 32'd1);
    check_val("ld2_addr", daddr, a0 + 32'd4);
    check_val("ld2_trans", {31'b0, cctrans}, {31'b0, exp_trans});
    step();
    dwait = 1'b1;
    dload = '0;
    #1;
    check_val("ld_done_dren", {31'b0, dREN}, 32'd0);
    check_val("ld_done_trans", {31'b0, cctrans}, 32'd0);
  endtask

  // Two-word write-back with zero wait states; entered while the FSM is in WB1.
  task automatic bus_wb(input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] d1);
    dwait = 1'b0;
    #1;
    check_val("wb1_dwen", {31'b0, dWEN}, 32'd1);
    check_val("wb1_addr", daddr, a0);
    check_val("wb1_data", dstore, d0);
    step();
    #1;
    check_val("wb2_dwen", {31'b0, dWEN}, 32'd1);
    check_val("wb2_addr", daddr, a0 + 32'd4);
    check_val("wb2_data", dstore, d1);
    step();
  endtask

  // Snoop pulse of one cycle on addr; checks the live ccwrite/dstore response.
  task automatic snoop(input logic [31:0] addr, input logic inv, input logic exp_ccw,
                       input logic [31:0] exp_data);
    ccwait      = 1'b1;
    ccinv       = inv;
    ccsnoopaddr = addr;
    #1;
    check_val("snp_ccwrite", {31'b0, ccwrite}, {31'b0, exp_ccw});
    if (exp_ccw) check_val("snp_dstore", dstore, exp_data);
    step();
    ccwait = 1'b0;
    ccinv  = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;  dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'h40; dmemstore = '0;
    dload = '0;   dwait = 1'b1;   ccwait = 1'b0;  ccinv = 1'b0;     ccsnoopaddr = '0;
    step();
    step();
    check_val("rst_dhit", {31'b0, dhit}, 32'd0);
    check_val("rst_dren", {31'b0, dREN}, 32'd0);
    check_val("rst_dwen", {31'b0, dWEN}, 32'd0);
    check_val("rst_ccwrite", {31'b0, ccwrite}, 32'd0);
    check_val("rst_cctrans", {31'b0, cctrans}, 32'd0);
    check_val("rst_daddr", daddr, 32'd0);
    check_val("rst_dstore", dstore, 32'd0);
    check_val("rst_dmemload", dmemload, 32'd0);
    nRST = 1'b1;

    // Read miss on a clean set, one wait cycle per word.
    dmemREN = 1'b1; dmemaddr = 32'h40;
    #1;
    check_val("rm_idle_dhit", {31'b0, dhit}, 32'd0);
    check_val("rm_idle_dren", {31'b0, dREN}, 32'd0);
    step();
    check_val("rm_ld1_dren", {31'b0, dREN}, 32'd1);
    check_val("rm_ld1_addr", daddr, 32'h40);
    check_val("rm_ld1_trans", {31'b0, cctrans}, 32'd0);
    step();
    dwait = 1'b0; dload = 32'hAAAA0000;
    step();
    dwait = 1'b1;
    #1;
    check_val("rm_ld2_dren", {31'b0, dREN}, 32'd1);
    check_val("rm_ld2_addr", daddr, 32'h44);
    step();
    dwait = 1'b0; dload = 32'hAAAA0001;
    step();
    dwait = 1'b1;
    #1;
    check_val("rm_hit", {31'b0, dhit}, 32'd1);
    check_val("rm_data0", dmemload, 32'hAAAA0000);
    dmemaddr = 32'h44;
    #1;
    check_val("rm_data1", dmemload, 32'hAAAA0001);
    dmemREN = 1'b0;
    snoop(32'h40, 1'b0, 1'b0, 32'h0);
    step();

    // Write to an S line upgrades through LD1/LD2 with cctrans.
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hDEADBEEF;
    #1;
    check_val("wu_idle_dhit", {31'b0, dhit}, 32'd0);
    step();
    bus_ld(32'h40, 32'h11110000, 32'h11110001, 1'b1);
    check_val("wu_hit", {31'b0, dhit}, 32'd1);
    step();
    dmemWEN = 1'b0; dmemREN = 1'b1;
    #1;
    check_val("wu_rd_hit", {31'b0, dhit}, 32'd1);
    check_val("wu_rd_data", dmemload, 32'hDEADBEEF);

    // Read miss to the same index evicts the Modified victim first.
    dmemaddr = 32'h80;
    #1;
    check_val("wb_idle_dhit", {31'b0, dhit}, 32'd0);
    step();
    bus_wb(32'h40, 32'hDEADBEEF, 32'h11110001);
    bus_ld(32'h80, 32'hBBBB0000, 32'hBBBB0001, 1'b0);
    check_val("wb_hit", {31'b0, dhit}, 32'd1);
    check_val("wb_data", dmemload, 32'hBBBB0000);

    // Make 0x40 Modified again, then snoop-read it (downgrade to S).
    dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hCAFE0000;
    step();
    bus_ld(32'h40, 32'h22220000, 32'h22220001, 1'b1);
    step();
    dmemWEN = 1'b0;
    snoop(32'h44, 1'b0, 1'b1, 32'h22220001);
    step();
    snoop(32'h44, 1'b0, 1'b0, 32'h0);
    dmemREN = 1'b1;
    #1;
    check_val("sd_rd_hit", {31'b0, dhit}, 32'd1);
    check_val("sd_rd_data", dmemload, 32'hCAFE0000);

    // Upgrade again, write word1, then snoop with invalidate.
    dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h44; dmemstore = 32'h5555AAAA;
    step();
    bus_ld(32'h40, 32'h33330000, 32'h33330001, 1'b1);
    step();
    dmemWEN = 1'b0;
    snoop(32'h44, 1'b1, 1'b1, 32'h5555AAAA);
    step();
    dmemREN = 1'b1; dmemaddr = 32'h40;
    #1;
    check_val("si_rd_miss", {31'b0, dhit}, 32'd0);
    step();
    bus_ld(32'h40, 32'h44440000, 32'h44440001, 1'b0);
    check_val("si_refill_hit", {31'b0, dhit}, 32'd1);

    // Snoop downgrade lands on the same edge as a processor write to that set.
    dmemREN = 1'b0; dmemWEN = 1'b1; dmemstore = 32'h77777777;
    step();
    bus_ld(32'h40, 32'h55550000, 32'h55550001, 1'b1);
    step();
    dmemWEN = 1'b0;
    snoop(32'h40, 1'b0, 1'b1, 32'h77777777);
    dmemWEN = 1'b1; dmemstore = 32'h99999999;
    #1;
    check_val("cf_dhit_supp", {31'b0, dhit}, 32'd0);
    step();
    dmemWEN = 1'b0; dmemREN = 1'b1;
    #1;
    check_val("cf_rd_hit", {31'b0, dhit}, 32'd1);
    check_val("cf_rd_data", dmemload, 32'h77777777);

    // Snoop masks the bus request; then reset lands in LD2.
    dmemaddr = 32'h100;
    step();
    ccwait = 1'b1; ccsnoopaddr = 32'h200;
    #1;
    check_val("mask_dren", {31'b0, dREN}, 32'd0);
    check_val("mask_ccwrite", {31'b0, ccwrite}, 32'd0);
    step();
    ccwait = 1'b0;
    #1;
    check_val("unmask_dren", {31'b0, dREN}, 32'd1);
    dwait = 1'b0; dload = 32'hCCCC0000;
    step();
    #1;
    check_val("rs_ld2_addr", daddr, 32'h104);
    nRST = 1'b0;
    #1;
    check_val("rs_dhit", {31'b0, dhit}, 32'd0);
    check_val("rs_dren", {31'b0, dREN}, 32'd0);
    check_val("rs_dwen", {31'b0, dWEN}, 32'd0);
    check_val("rs_cctrans", {31'b0, cctrans}, 32'd0);
    check_val("rs_daddr", daddr, 32'd0);
    check_val("rs_dstore", dstore, 32'd0);
    check_val("rs_dmemload", dmemload, 32'd0);
    step();
    dwait = 1'b1; nRST = 1'b1; dmemaddr = 32'h40;
    #1;
    check_val("rs_rd_miss", {31'b0, dhit}, 32'd0);
    step();
    check_val("rs_ld1_dren", {31'b0, dREN}, 32'd1);
    check_val("rs_ld1_addr", daddr, 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
